// File: rtl/sram1p_pipe_pkg.sv
// Shared definitions for the pipelined single-port SRAM: FSM state encodings,
// a clog2 helper and the parameter-legality check used at elaboration.
package sram1p_pipe_pkg;

  typedef enum logic [1:0] {
    SRAM_ST_RESET = 2'd0,
    SRAM_ST_CLEAR = 2'd1,
    SRAM_ST_READY = 2'd2
  } sramState_e;

  localparam int unsigned MIN_READ_LATENCY = 1;
  localparam int unsigned MAX_READ_LATENCY = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

  // Word must split evenly into mask bytes and the read latency must be supported.
  function automatic bit paramsLegal(input int unsigned wordSize,
                                     input int unsigned byteSize,
                                     input int unsigned readLatency);
    return (byteSize != 0) && ((wordSize % byteSize) == 0) &&
           (readLatency >= MIN_READ_LATENCY) && (readLatency <= MAX_READ_LATENCY);
  endfunction

endpackage

// File: rtl/sram1p_pipe_if.sv
// Request/response bundle of the pipelined single-port SRAM; the requester
// uses the master modport, the memory the slave modport.
interface sram1p_pipe_if #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned BYTE_SIZE = 8
);
  localparam int unsigned NUM_BYTES = WORD_SIZE / BYTE_SIZE;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic [NUM_BYTES-1:0] req_wmask;
  logic                 resp_valid;
  logic [WORD_SIZE-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/sram1p_pipe_mask_array.sv
// Bare storage array with per-byte write enables and one registered read stage.
// Contents are never reset; only the read register clears on rst.
module sram1p_mask_array #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned BYTE_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [ADDR_SIZE-1:0]           addr_i,
  input  logic [WORD_SIZE-1:0]           wdata_i,
  input  logic [WORD_SIZE/BYTE_SIZE-1:0] wmask_i,
  output logic [WORD_SIZE-1:0]           rdata_o
);
  localparam int unsigned NUM_BYTES = WORD_SIZE / BYTE_SIZE;
  localparam int unsigned DEPTH     = 1 << ADDR_SIZE;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (wmask_i[i]) mem_q[addr_i][i*BYTE_SIZE +: BYTE_SIZE] <= wdata_i[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram1p_pipe.sv
// Single-port SRAM with byte mask, valid/ready requests and a READ_LATENCY read pipe.
// Define SRAM1P_PIPE_INIT_CLEAR_EN to zero the whole array after every reset.
module sram1p_pipe
  import sram1p_pipe_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 64,
  parameter int unsigned ADDR_SIZE    = 10,
  parameter int unsigned BYTE_SIZE    = 8,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic          clk,
  input logic          rst,
  sram1p_pipe_if.slave bus
);
  localparam int unsigned NUM_BYTES = WORD_SIZE / BYTE_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

  if (!paramsLegal(WORD_SIZE, BYTE_SIZE, READ_LATENCY)) begin : gBadParams
    $error("sram1p_pipe: WORD_SIZE must be a multiple of BYTE_SIZE and READ_LATENCY in 1..4");
  end

  sramState_e           state_q, state_d;
  logic [ADDR_SIZE-1:0] clearCnt_q, clearCnt_d;
  logic                 clearWe;
  logic                 ready;
  logic                 accept;
  logic                 arrWe;
  logic                 arrRe;
  logic                 rdValid_q;
  logic [ADDR_SIZE-1:0] arrAddr;
  logic [WORD_SIZE-1:0] arrWdata;
  logic [WORD_SIZE-1:0] arrRdata;
  logic [NUM_BYTES-1:0] arrWmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SRAM_ST_RESET;
      clearCnt_q <= '0;
      rdValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clearCnt_q <= clearCnt_d;
      rdValid_q  <= arrRe;
    end
  end

  // The sweep writes address 0 already in the RESET cycle so that ready rises
  // exactly 2^ADDR_SIZE cycles after reset release.
  always_comb begin
    state_d    = state_q;
    clearCnt_d = clearCnt_q;
    clearWe    = 1'b0;
    unique case (state_q)
      SRAM_ST_RESET: begin
`ifdef SRAM1P_PIPE_INIT_CLEAR_EN
        clearWe    = 1'b1;
        clearCnt_d = clearCnt_q + 1'b1;
        state_d    = (clearCnt_q == LAST_ADDR) ? SRAM_ST_READY : SRAM_ST_CLEAR;
`else
        state_d    = SRAM_ST_READY;
`endif
      end
      SRAM_ST_CLEAR: begin
        clearWe    = 1'b1;
        clearCnt_d = clearCnt_q + 1'b1;
        if (clearCnt_q == LAST_ADDR) state_d = SRAM_ST_READY;
      end
      SRAM_ST_READY: state_d = SRAM_ST_READY;
      default:       state_d = SRAM_ST_RESET;
    endcase
  end

  assign ready         = (state_q == SRAM_ST_READY);
  assign bus.req_ready = ready;
  assign accept        = bus.req_valid && ready && !rst;
  assign arrWe         = !rst && (clearWe || (accept && bus.req_write));
  assign arrRe         = accept && !bus.req_write;
  assign arrAddr       = clearWe ? clearCnt_q : bus.req_addr;
  assign arrWdata      = clearWe ? '0 : bus.req_wdata;
  assign arrWmask      = clearWe ? '1 : bus.req_wmask;

  sram1p_mask_array #(
    .WORD_SIZE (WORD_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .BYTE_SIZE (BYTE_SIZE)
  ) uArray (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arrWe),
    .re_i    (arrRe),
    .addr_i  (arrAddr),
    .wdata_i (arrWdata),
    .wmask_i (arrWmask),
    .rdata_o (arrRdata)
  );

  if (READ_LATENCY == 1) begin : gNoDelay
    assign bus.resp_valid = rdValid_q;
    assign bus.resp_rdata = arrRdata;
  end else begin : gDelay
    localparam int unsigned STAGES = READ_LATENCY - 1;

    logic [STAGES-1:0]    pipeValid_q;
    logic [WORD_SIZE-1:0] pipeData_q [STAGES];

    // Data only moves alongside a valid bit, so the last stage holds the most
    // recent response between pulses.
    always_ff @(posedge clk) begin
      if (rst) begin
        pipeValid_q <= '0;
        for (int unsigned i = 0; i < STAGES; i++) pipeData_q[i] <= '0;
      end else begin
        pipeValid_q[0] <= rdValid_q;
        if (rdValid_q) pipeData_q[0] <= arrRdata;
        for (int unsigned i = 1; i < STAGES; i++) begin
          pipeValid_q[i] <= pipeValid_q[i-1];
          if (pipeValid_q[i-1]) pipeData_q[i] <= pipeData_q[i-1];
        end
      end
    end

    assign bus.resp_valid = pipeValid_q[STAGES-1];
    assign bus.resp_rdata = pipeData_q[STAGES-1];
  end

endmodule
